// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a fetch PC drives a combinational-read instruction
// memory, and each fetched {pc, instr} pair is queued for the decode stage.
// A redirect flushes the queue and restarts fetch at a word-aligned target.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    output logic [31:0]              imemAddr,
    input  logic [31:0]              imemData,
    input  logic                     redirect,
    input  logic [31:0]              redirectPc,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [31:0]              outInstr,
    output logic [31:0]              outPc,
    output logic [31:0]              outPcPlus4,
`ifdef FETCH_STATS_EN
    output logic [31:0]              statFetched,
    output logic [31:0]              statFlushed,
    output logic [31:0]              statStall,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          push;
    logic          pop;
    logic          full;

    assign full       = (count == FULL_COUNT);
    assign imemAddr   = fetch_pc;
    assign outValid   = (count != '0) && !redirect;
    assign pop        = outValid && outReady;
    // A redirect suppresses both push and pop; a full queue may still push
    // when the head leaves in the same cycle.
    assign push       = !redirect && (!full || pop);
    assign outPc      = pc_mem[rd_ptr];
    assign outInstr   = instr_mem[rd_ptr];
    assign outPcPlus4 = pc_mem[rd_ptr] + 32'd4;

    // Control state: fetch PC, pointers and occupancy; reset beats redirect.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirectPc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage is written on push only and never needs a reset value.
    always_ff @(posedge clkIn) begin
        if (push && !rstIn) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imemData;
        end
    end

`ifdef FETCH_STATS_EN
    // Statistics: fetched words, entries discarded by redirects, full-stall cycles.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            statFetched <= '0;
            statFlushed <= '0;
            statStall   <= '0;
        end else begin
            if (push) begin
                statFetched <= statFetched + 32'd1;
            end
            if (redirect) begin
                statFlushed <= statFlushed + 32'(count);
            end
            if (full && !pop) begin
                statStall <= statStall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  DEPTH  4  queue entries; power of two, minimum 2.
  RESET_PC  32'h0000_0000  first fetch address after reset.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  clkIn  in  1  single clock; all state changes on its rising edge.
  rstIn  in  1  synchronous, active-high reset.
  imemAddr  out  32  address to the combinational-read instruction memory.
  imemData  in  32  instruction word at imemAddr, valid in the same cycle.
  redirect  in  1  taken branch/jump from the execute stage; flushes the queue.
  redirectPc  in  32  new fetch address, sampled when redirect=1.
  outValid  out  1  head entry available to the decode/datapath stage.
  outReady  in  1  consumer accepts the head entry this cycle.
  outInstr  out  32  head instruction word.
  outPc  out  32  address of the head instruction.
  outPcPlus4  out  32  outPc+4, modulo 2^32.
  count  out  log2(DEPTH)+1  current occupancy.
REQ-003 Clocking SHALL use one clock, clkIn, and reset SHALL be rstIn, synchronous and active-high.

Function
REQ-004 A fetch PC register SHALL drive imemAddr directly.
REQ-005 Push SHALL occur when redirect=0 and (count<DEPTH or a pop occurs in the same cycle).
  - On push, {fetchPc, imemData} SHALL be written at the tail.
  - On push, fetchPc SHALL be updated to fetchPc+4, wrapping from 32'hFFFF_FFFC to 0.
REQ-006 When no push occurs, fetchPc SHALL hold.
REQ-007 Pop SHALL occur when outValid=1 and outReady=1.
  - On pop, the head SHALL advance by one entry.
REQ-008 outValid SHALL equal (count!=0) && !redirect.
REQ-009 outInstr, outPc and outPcPlus4 SHALL reflect the head entry.
REQ-010 outInstr, outPc and outPcPlus4 SHALL be don't-care when outValid=0.
REQ-011 Latency: a word pushed at edge N SHALL be visible at the head no earlier than the cycle after edge N; there is no combinational imemData-to-outInstr path.
REQ-012 Entries SHALL be delivered in push order, with no duplication and no loss.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH.
REQ-014 count SHALL change by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-015 Full: with count=DEPTH and no pop, there SHALL be no push and fetchPc SHALL hold.
REQ-016 Full: with count=DEPTH and a simultaneous pop, push SHALL proceed and count SHALL remain DEPTH.
REQ-017 Empty: with count=0, outValid=0 and outReady SHALL be ignored.
REQ-018 On redirect=1 the following SHALL happen at the next edge:
  - count SHALL become 0;
  - both pointers SHALL be reset;
  - fetchPc SHALL become {redirectPc[31:2], 2'b00};
  - no push and no pop SHALL occur that cycle, regardless of outReady.
REQ-019 Redirect takes priority over full, empty and simultaneous push/pop.
REQ-020 Back-to-back redirects SHALL each take effect, and the last one wins.
REQ-021 redirectPc[1:0] SHALL be ignored; misaligned targets are forced to word alignment.

Reset
REQ-022 While rstIn=1 at an edge, the following SHALL hold at that edge:
  - fetchPc SHALL become RESET_PC with the low 2 bits forced to 0;
  - count SHALL become 0;
  - pointers SHALL become 0;
  - outValid SHALL become 0.
REQ-023 rstIn SHALL dominate redirect and all push/pop activity.
REQ-024 rstIn asserted mid-stream SHALL discard all queued entries.
REQ-025 Queue storage SHALL NOT require reset.
REQ-026 In the first cycle after rstIn deasserts, imemAddr SHALL equal RESET_PC and a push SHALL occur.

Configuration
REQ-027 Macro FETCH_STATS_EN, when defined, SHALL add the following outputs, each counting per clkIn edge and wrapping at 2^32:
  - statFetched (out, 32): incremented on every push;
  - statFlushed (out, 32): incremented by the count value discarded on each redirect;
  - statStall (out, 32): incremented each cycle with count=DEPTH and no pop.
REQ-028 All FETCH_STATS_EN counters SHALL reset to 0 on rstIn.
REQ-029 When FETCH_STATS_EN is undefined, those ports and counters SHALL be absent.
REQ-030 When FETCH_STATS_EN is undefined, all other behaviour SHALL be identical to the defined case.

Verification
REQ-031 Reset release with outReady=1 and memory holding word k = 32'h2000_0000+k:
  - outValid SHALL rise one cycle after the first push;
  - outPc SHALL be 0, 4, 8, ... on consecutive cycles;
  - outInstr SHALL match the memory contents.
REQ-032 Fill with outReady=0 for 10 cycles:
  - count SHALL saturate at 4 and imemAddr SHALL hold at 16;
  - after outReady=1, entries SHALL drain with PCs 0, 4, 8, 12, 16 in order.
REQ-033 Full with outReady=1 steady: count SHALL stay 4 and fetchPc SHALL advance by 4 every cycle.
REQ-034 redirect=1 with redirectPc=32'h0000_0043, queue holding 3 entries, and outReady=1:
  - no pop SHALL occur that cycle;
  - the next edge SHALL give count=0 and imemAddr=32'h0000_0040;
  - the next delivered outPc SHALL be 32'h40;
  - with FETCH_STATS_EN defined, statFlushed SHALL be 3.
REQ-035 rstIn pulsed while count=4 and redirect=1:
  - count SHALL become 0 and imemAddr SHALL become RESET_PC;
  - with FETCH_STATS_EN defined, all counters SHALL be 0.
REQ-036 fetchPc wrap: after redirectPc=32'hFFFF_FFF8, outPc SHALL sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - outPcPlus4 for FFFF_FFFC SHALL be 0.
